mem_port_arbiter: RTL

- Shares the single external AXI block-memory port between the instruction cache (refill reads) and the data cache (refill reads, dirty writebacks).
- Sits between the caches/control unit and the AXI master.
- Serialises requests with one transaction in flight at a time.
- Routes 512-bit blocks, the address and completion pulses to the owning requester.
- Flags hung transactions with a timeout.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter_timeout.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding, requester ids
// and the round-robin helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_I = 2'd1,
        RD_D = 2'd2,
        WR_D = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    localparam int BLOCK_BYTES = 64;

    function automatic req_id_e other_reader(input req_id_e cur);
        return (cur == REQ_I) ? REQ_D : REQ_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and AXI-side signals around the memory port arbiter.
// The slave modport is the arbiter's view; master is the caches/AXI side.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH  = 64,
    parameter int BLOCK_WIDTH = 512
);
    logic                   i_i_rd_req;
    logic [ADDR_WIDTH-1:0]  i_i_addr;
    logic                   i_d_rd_req;
    logic                   i_d_wr_req;
    logic [ADDR_WIDTH-1:0]  i_d_addr;
    logic [BLOCK_WIDTH-1:0] i_d_wdata;
    logic                   i_read_last_axi;
    logic                   i_b_resp_axi;
    logic                   o_start_read_axi;
    logic                   o_start_write_axi;
    logic [ADDR_WIDTH-1:0]  o_addr_axi;
    logic [BLOCK_WIDTH-1:0] o_data_write_axi;
    logic                   o_i_done;
    logic                   o_d_rd_done;
    logic                   o_d_wr_done;
    logic                   o_busy;
    logic                   o_timeout_err;

    modport slave (
        input  i_i_rd_req, i_i_addr, i_d_rd_req, i_d_wr_req, i_d_addr, i_d_wdata,
               i_read_last_axi, i_b_resp_axi,
        output o_start_read_axi, o_start_write_axi, o_addr_axi, o_data_write_axi,
               o_i_done, o_d_rd_done, o_d_wr_done, o_busy, o_timeout_err
    );

    modport master (
        output i_i_rd_req, i_i_addr, i_d_rd_req, i_d_wr_req, i_d_addr, i_d_wdata,
               i_read_last_axi, i_b_resp_axi,
        input  o_start_read_axi, o_start_write_axi, o_addr_axi, o_data_write_axi,
               o_i_done, o_d_rd_done, o_d_wr_done, o_busy, o_timeout_err
    );

endinterface

// File: rtl/mem_port_arbiter_timeout.sv
// Per-transaction watchdog: counts busy cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT_CYCLES-1. TIMEOUT_CYCLES=0 disables it.
module arb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit ENABLED = (TIMEOUT_CYCLES != 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating at LIMIT keeps the disabled case pinned at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = ENABLED && run_i && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single AXI block-memory port between I-cache refills and D-cache
// refills/writebacks, one transaction in flight, with a per-transaction timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int BLOCK_WIDTH    = 512,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_e             state_q;
    req_id_e                rr_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [BLOCK_WIDTH-1:0] wdata_q;
    logic                   start_rd_q;
    logic                   start_wr_q;
    logic                   busy_q;
    logic                   err_q;

    logic idle;
    logic gnt_wr;
    logic gnt_i;
    logic gnt_d;
    logic gnt_any;
    logic done_i;
    logic done_d;
    logic done_w;
    logic xact_done;
    logic tmo_expired;

    // Writeback beats both reads so dirty data leaves before the refill of its set.
    assign idle    = (state_q == IDLE);
    assign gnt_wr  = idle && bus.i_d_wr_req;
    assign gnt_i   = idle && !bus.i_d_wr_req && bus.i_i_rd_req &&
                     (!bus.i_d_rd_req || (rr_q == REQ_I));
    assign gnt_d   = idle && !bus.i_d_wr_req && bus.i_d_rd_req &&
                     (!bus.i_i_rd_req || (rr_q == REQ_D));
    assign gnt_any = gnt_wr || gnt_i || gnt_d;

    assign done_i    = (state_q == RD_I) && bus.i_read_last_axi;
    assign done_d    = (state_q == RD_D) && bus.i_read_last_axi;
    assign done_w    = (state_q == WR_D) && bus.i_b_resp_axi;
    assign xact_done = done_i || done_d || done_w;

    arb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (gnt_any),
        .run_i     (!idle),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_q       <= REQ_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            start_rd_q <= 1'b0;
            start_wr_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            start_rd_q <= gnt_i || gnt_d;
            start_wr_q <= gnt_wr;
            unique case (state_q)
                IDLE: begin
                    if (gnt_wr) begin
                        state_q <= WR_D;
                        addr_q  <= bus.i_d_addr;
                        wdata_q <= bus.i_d_wdata;
                        busy_q  <= 1'b1;
                    end else if (gnt_i) begin
                        state_q <= RD_I;
                        addr_q  <= bus.i_i_addr;
                        rr_q    <= other_reader(REQ_I);
                        busy_q  <= 1'b1;
                    end else if (gnt_d) begin
                        state_q <= RD_D;
                        addr_q  <= bus.i_d_addr;
                        rr_q    <= other_reader(REQ_D);
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    // Completion takes precedence over a timeout landing in the same cycle.
                    if (xact_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (tmo_expired) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.o_start_read_axi  = start_rd_q;
    assign bus.o_start_write_axi = start_wr_q;
    assign bus.o_addr_axi        = addr_q;
    assign bus.o_data_write_axi  = wdata_q;
    assign bus.o_i_done          = done_i;
    assign bus.o_d_rd_done       = done_d;
    assign bus.o_d_wr_done       = done_w;
    assign bus.o_busy            = busy_q;
    assign bus.o_timeout_err     = err_q;

endmodule
